// File: rtl/jesd204_versal_gt_adapter_tx_multi.sv
// Multi-lane 64b66b TX adapter from the JESD204 link layer to Versal GT.
// Bit-reverses data, swaps header bits, masks lanes, adds test patterns.
module jesd204_versal_gt_adapter_tx_multi #(
    parameter int         NUM_LANES  = 4,
    parameter bit         OUTPUT_REG = 1'b1,
    parameter logic [6:0] PRBS_SEED  = 7'h7F
) (
    input  logic                     usr_clk,
    input  logic                     reset,
    input  logic [NUM_LANES*64-1:0]  tx_data,
    input  logic [NUM_LANES*2-1:0]   tx_header,
    input  logic [1:0]               pattern_sel,
    input  logic [NUM_LANES-1:0]     lane_enable,
    output logic [NUM_LANES*128-1:0] txdata,
    output logic [NUM_LANES*6-1:0]   txheader,
    output logic                     pattern_active
);

    localparam logic [1:0]  MODE_NORMAL = 2'd0;
    localparam logic [1:0]  MODE_PRBS   = 2'd1;
    localparam logic [1:0]  MODE_ALT    = 2'd2;
    localparam logic [63:0] ALT_WORD    = 64'hAAAA_AAAA_AAAA_AAAA;

    logic [1:0]               r_mode;
    logic [6:0]               r_prbs;
    logic [6:0]               w_prbs_nxt;
    logic [63:0]              w_prbs_word;
    logic [NUM_LANES*128-1:0] w_txdata;
    logic [NUM_LANES*6-1:0]   w_txheader;
    logic                     w_active;

    // Pattern select is registered once before it steers the datapath
    always_ff @(posedge usr_clk or posedge reset) begin
        if (reset) r_mode <= MODE_NORMAL;
        else       r_mode <= pattern_sel;
    end

    // Unroll 64 serial PRBS7 steps; step k lands in word bit k
    always_comb begin
        logic [6:0] s;
        logic       b;
        s           = r_prbs;
        b           = 1'b0;
        w_prbs_word = '0;
        for (int k = 0; k < 64; k++) begin
            b              = s[6] ^ s[5];
            w_prbs_word[k] = b;
            s              = {s[5:0], b};
        end
        w_prbs_nxt = s;
    end

    // LFSR runs only in PRBS mode; elsewhere it sits at the seed
    always_ff @(posedge usr_clk or posedge reset) begin
        if (reset)                  r_prbs <= PRBS_SEED;
        else if (r_mode == MODE_PRBS) r_prbs <= w_prbs_nxt;
        else                        r_prbs <= PRBS_SEED;
    end

    // Per-lane source select, enable mask and GT bit mapping
    always_comb begin
        logic [63:0] d;
        logic [1:0]  h;
        w_txdata   = '0;
        w_txheader = '0;
        d          = '0;
        h          = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            d = '0;
            h = 2'b01;
            case (r_mode)
                MODE_NORMAL: begin
                    d = tx_data[64*n +: 64];
                    h = tx_header[2*n +: 2];
                end
                MODE_PRBS: d = w_prbs_word;
                MODE_ALT:  d = ALT_WORD;
                default:   d = '0;
            endcase
            if (!lane_enable[n]) begin
                d = '0;
                h = 2'b00;
            end
            for (int i = 0; i < 64; i++) begin
                w_txdata[128*n + i] = d[63-i];
            end
            w_txheader[6*n +: 6] = {4'b0000, h[0], h[1]};
        end
    end

    assign w_active = (r_mode != MODE_NORMAL);

    if (OUTPUT_REG) begin : g_oreg
        logic [NUM_LANES*128-1:0] r_txdata;
        logic [NUM_LANES*6-1:0]   r_txheader;
        logic                     r_active;

        // Retime GT-facing outputs; cleared immediately on reset
        always_ff @(posedge usr_clk or posedge reset) begin
            if (reset) begin
                r_txdata   <= '0;
                r_txheader <= '0;
                r_active   <= 1'b0;
            end else begin
                r_txdata   <= w_txdata;
                r_txheader <= w_txheader;
                r_active   <= w_active;
            end
        end

        assign txdata         = r_txdata;
        assign txheader       = r_txheader;
        assign pattern_active = r_active;
    end else begin : g_comb
        assign txdata         = w_txdata;
        assign txheader       = w_txheader;
        assign pattern_active = w_active;
    end

endmodule

// File: tb/tb_jesd204_versal_gt_adapter_tx_multi.sv
// Directed bench for the multi-lane Versal GT TX adapter.
// Vector table for normal mode plus hand sequences for patterns and reset.
module tb_jesd204_versal_gt_adapter_tx_multi;

    localparam int NL = 4;

    logic              usr_clk = 1'b0;
    logic              reset;
    logic [NL*64-1:0]  tx_data;
    logic [NL*2-1:0]   tx_header;
    logic [1:0]        pattern_sel;
    logic [NL-1:0]     lane_enable;
    logic [NL*128-1:0] txdata;
    logic [NL*6-1:0]   txheader;
    logic              pattern_active;

    int checks   = 0;
    int failures = 0;
    bit stream [0:126];

    typedef struct {
        logic [3:0][63:0] d;
        logic [3:0][1:0]  h;
        logic [3:0]       en;
        logic [3:0][63:0] ed;
        logic [3:0][5:0]  eh;
    } vec_t;

    vec_t vt [5];

    jesd204_versal_gt_adapter_tx_multi #(
        .NUM_LANES (NL),
        .OUTPUT_REG(1'b1),
        .PRBS_SEED (7'h7F)
    ) dut (
        .usr_clk       (usr_clk),
        .reset         (reset),
        .tx_data       (tx_data),
        .tx_header     (tx_header),
        .pattern_sel   (pattern_sel),
        .lane_enable   (lane_enable),
        .txdata        (txdata),
        .txheader      (txheader),
        .pattern_active(pattern_active)
    );

    always #5 usr_clk = ~usr_clk;

    task automatic tick;
        @(posedge usr_clk);
        #1;
    endtask

    task automatic chk_lane(input string nm, input int n,
                            input logic [63:0] ed, input logic [5:0] eh);
        logic [127:0] gd;
        logic [5:0]   gh;
        gd = txdata[n*128 +: 128];
        gh = txheader[n*6 +: 6];
        checks++;
        if (gd !== {64'h0, ed} || gh !== eh) begin
            failures++;
            $display("FAIL %s lane%0d: got data=%h hdr=%b, want data=%h hdr=%b",
                     nm, n, gd, gh, {64'h0, ed}, eh);
        end
    endtask

    task automatic chk_act(input string nm, input logic exp);
        checks++;
        if (pattern_active !== exp) begin
            failures++;
            $display("FAIL %s: got pattern_active=%b, want %b",
                     nm, pattern_active, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if (txdata !== '0 || txheader !== '0 || pattern_active !== 1'b0) begin
            failures++;
            $display("FAIL %s: got txdata=%h txheader=%h act=%b, want all zero",
                     nm, txdata, txheader, pattern_active);
        end
    endtask

    // Expected GT word c: GT bit i carries stream bit 64c + 63 - i
    function automatic logic [63:0] exp_prbs(input int c);
        logic [63:0] e;
        for (int i = 0; i < 64; i++) e[i] = stream[(64*c + 63 - i) % 127];
        return e;
    endfunction

    localparam logic [63:0] A0  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] A1  = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] A2  = 64'h0000_0000_0000_00F0;
    localparam logic [63:0] A3  = 64'h8000_0000_0000_0003;
    localparam logic [63:0] RA0 = 64'hF7B3_D591_E6A2_C480;
    localparam logic [63:0] RA1 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] RA2 = 64'h0F00_0000_0000_0000;
    localparam logic [63:0] RA3 = 64'hC000_0000_0000_0001;
    localparam logic [63:0] ALT = 64'h5555_5555_5555_5555;

    initial begin
        logic [6:0] s;
        logic       b;
        s = 7'h7F;
        for (int j = 0; j < 127; j++) begin
            b         = s[6] ^ s[5];
            stream[j] = b;
            s         = {s[5:0], b};
        end

        vt[0].d  = {64'h0, 64'h0, 64'h0, 64'h1};
        vt[0].h  = {2'b00, 2'b00, 2'b00, 2'b10};
        vt[0].en = 4'hF;
        vt[0].ed = {64'h0, 64'h0, 64'h0, 64'h8000_0000_0000_0000};
        vt[0].eh = {6'b0, 6'b0, 6'b0, 6'b000001};

        vt[1].d  = {A3, A2, A1, A0};
        vt[1].h  = {2'b00, 2'b11, 2'b10, 2'b01};
        vt[1].en = 4'hF;
        vt[1].ed = {RA3, RA2, RA1, RA0};
        vt[1].eh = {6'b000000, 6'b000011, 6'b000001, 6'b000010};

        vt[2].d  = {A3, A2, A1, A0};
        vt[2].h  = {2'b00, 2'b11, 2'b10, 2'b01};
        vt[2].en = 4'b1010;
        vt[2].ed = {RA3, 64'h0, RA1, 64'h0};
        vt[2].eh = {6'b000000, 6'b0, 6'b000001, 6'b0};

        vt[3].d  = {A3, A2, A1, A0};
        vt[3].h  = {2'b00, 2'b11, 2'b10, 2'b01};
        vt[3].en = 4'b0101;
        vt[3].ed = {64'h0, RA2, 64'h0, RA0};
        vt[3].eh = {6'b0, 6'b000011, 6'b0, 6'b000010};

        vt[4].d  = {A0, A1, A2, A3};
        vt[4].h  = {2'b10, 2'b10, 2'b10, 2'b10};
        vt[4].en = 4'hF;
        vt[4].ed = {RA0, RA1, RA2, RA3};
        vt[4].eh = {6'b000001, 6'b000001, 6'b000001, 6'b000001};

        reset       = 1'b0;
        tx_data     = '0;
        tx_header   = '0;
        pattern_sel = 2'd0;
        lane_enable = 4'hF;
        #1 reset = 1'b1;
        #1 chk_zero("reset_state");
        tick;
        tick;
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            tx_data     = vt[v].d;
            tx_header   = vt[v].h;
            lane_enable = vt[v].en;
            tick;
            for (int n = 0; n < NL; n++)
                chk_lane($sformatf("vec%0d", v), n, vt[v].ed[n], vt[v].eh[n]);
            chk_act($sformatf("vec%0d_act", v), 1'b0);
        end

        tx_data     = '0;
        tx_header   = '0;
        lane_enable = 4'hF;
        pattern_sel = 2'd1;
        tick;
        chk_act("prbs_act_1cyc", 1'b0);
        tick;
        chk_act("prbs_act_2cyc", 1'b1);
        for (int c = 0; c < 130; c++) begin
            chk_lane($sformatf("prbs_w%0d", c), 0, exp_prbs(c), 6'b000010);
            chk_lane($sformatf("prbs_w%0d", c), 3, exp_prbs(c), 6'b000010);
            tick;
        end

        pattern_sel = 2'd2;
        lane_enable = 4'b0110;
        tick;
        tick;
        chk_lane("alt", 0, 64'h0, 6'b0);
        chk_lane("alt", 1, ALT, 6'b000010);
        chk_lane("alt", 2, ALT, 6'b000010);
        chk_lane("alt", 3, 64'h0, 6'b0);
        chk_act("alt_act", 1'b1);

        pattern_sel = 2'd1;
        tick;
        chk_lane("alt_hold", 1, ALT, 6'b000010);
        tick;
        chk_lane("prbs_again_w0", 1, exp_prbs(0), 6'b000010);
        for (int c = 1; c < 10; c++) tick;
        chk_lane("prbs_again_w9", 2, exp_prbs(9), 6'b000010);

        pattern_sel = 2'd3;
        tick;
        chk_lane("pre_const", 1, exp_prbs(10), 6'b000010);
        tick;
        chk_lane("const", 1, 64'h0, 6'b000010);
        chk_lane("const_mask", 0, 64'h0, 6'b0);
        chk_act("const_act", 1'b1);

        pattern_sel = 2'd1;
        tick;
        chk_lane("const_hold", 2, 64'h0, 6'b000010);
        tick;
        chk_lane("reentry_w0", 1, exp_prbs(0), 6'b000010);
        tick;
        tick;
        chk_lane("reentry_w2", 2, exp_prbs(2), 6'b000010);

        tx_data     = vt[1].d;
        tx_header   = vt[1].h;
        lane_enable = 4'hF;
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        pattern_sel = 2'd0;
        tick;
        chk_zero("reset_held");
        reset = 1'b0;
        tick;
        for (int n = 0; n < NL; n++)
            chk_lane("post_reset", n, vt[1].ed[n], vt[1].eh[n]);
        chk_act("post_reset_act", 1'b0);

        pattern_sel = 2'd1;
        tick;
        tick;
        chk_lane("post_reset_prbs", 0, exp_prbs(0), 6'b000010);
        chk_act("post_reset_prbs_act", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jesd204_versal_gt_adapter_tx_multi.md
Name: jesd204_versal_gt_adapter_tx_multi

Overview:
- Multi-lane 64b66b TX adapter between the JESD204 link layer and Versal GT transmitters.
- Per lane, in normal mode: bit-reverses the 64-bit data word, swaps the 2 sync-header bits, and zero-pads to the GT widths (128-bit data, 6-bit header).
- Adds per-lane enable masking, an optional output register, and a built-in test-pattern source (PRBS7, alternating, constant) for link bring-up.

Parameters:
- NUM_LANES, 4, number of lanes (1..16).
- OUTPUT_REG, 1, 1 = register the GT-facing outputs; 0 = combinational outputs.
- PRBS_SEED, 7'h7F, PRBS7 LFSR load value; must be non-zero.

Ports:
- usr_clk  input  1  lane/user clock; all logic runs on it.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  NUM_LANES*64  link-layer data; lane n occupies [64n+63:64n].
- tx_header  input  NUM_LANES*2  link-layer sync header; lane n occupies [2n+1:2n].
- pattern_sel  input  2  0 = normal, 1 = PRBS7, 2 = alternating, 3 = constant.
- lane_enable  input  NUM_LANES  1 = lane active; 0 = lane outputs forced to zero.
- txdata  output  NUM_LANES*128  GT data; lane n occupies [128n+127:128n].
- txheader  output  NUM_LANES*6  GT header; lane n occupies [6n+5:6n].
- pattern_active  output  1  high while the outputs carry a test pattern.

Behaviour:
- Mode register:
  - mode_q <= pattern_sel every usr_clk cycle.
  - Reset value is 0 (normal mode).
- Stage-0 word per lane n, before masking (d = 64-bit word, h = 2-bit header):
  - mode_q=0: d = tx_data lane n; h = tx_header lane n.
  - mode_q=1: d = current PRBS word; h = 2'b01. All lanes carry the identical word.
  - mode_q=2: d = 64'hAAAA_AAAA_AAAA_AAAA; h = 2'b01.
  - mode_q=3: d = 64'h0; h = 2'b01.
- Masking: if lane_enable[n]=0, d = 0 and h = 2'b00 for that lane. The mask applies at stage 0, with the same latency as data.
- GT mapping per lane:
  - txdata lane[i] = d[63-i] for i = 0..63.
  - txdata lane[127:64] = 0.
  - txheader lane = {4'b0, h[0], h[1]}.
- PRBS7 generator (polynomial x^7+x^6+1, 7-bit state s):
  - One serial step: b = s[6]^s[5]; s <= {s[5:0], b}.
  - Per cycle the generator takes 64 serial steps. The k-th generated bit (k = 0..63) goes to d[k], i.e. the first bit is the LSB before reversal. State after step 63 is kept.
  - When mode_q != 1, s is held at PRBS_SEED. This makes the first PRBS word after entering mode 1 always start from the seed.
  - While mode_q == 1, s advances 64 steps per cycle.
  - The bit stream repeats with period 127 bits. The word sequence repeats every 127 cycles.
- Latency:
  - tx_data/tx_header/lane_enable to outputs: OUTPUT_REG cycles (0 = same cycle).
  - pattern_sel to outputs: 1 + OUTPUT_REG cycles.
  - pattern_active = (mode_q != 0), delayed by OUTPUT_REG so it aligns with the outputs.
- Reset:
  - Asynchronous assertion: mode_q = 0, s = PRBS_SEED.
  - With OUTPUT_REG=1: txdata, txheader and pattern_active registers are cleared to 0 immediately.
  - With OUTPUT_REG=0: outputs follow the normal-mode combinational path during reset.
  - Reset mid-pattern: on release the block starts in normal mode; the PRBS restarts from the seed on the next entry to mode 1.
- Simultaneous events:
  - A pattern_sel change and a lane_enable change in the same cycle each take effect at their own latencies.
  - A mode change 1 -> 2 -> 1 reseeds the PRBS (no resume).
- No handshake: the block accepts a word every cycle and never stalls.

Test Plan:
- Normal mode, OUTPUT_REG=1, lane0 tx_data = 64'h0000_0000_0000_0001, tx_header = 2'b10 -> one cycle later txdata lane0 = {64'h0, 64'h8000_0000_0000_0000}, txheader lane0 = 6'b000001; pattern_active = 0.
- All lanes distinct data, lane_enable = 4'b1010 -> lanes 0 and 2 output txdata = 0 and txheader = 0; lanes 1 and 3 carry their own bit-reversed words.
- pattern_sel = 1 from reset -> output sequence matches a serial PRBS7 reference model seeded with 7'h7F, bit-reversed per word, txheader = 6'b000010. The sequence repeats after 127 cycles, and pattern_active rises 2 cycles after pattern_sel.
- pattern_sel = 2 -> txdata lane[63:0] = 64'h5555_5555_5555_5555, txheader = 6'b000010 on every enabled lane.
- Sequence 1 (10 cycles) -> 3 -> 1 -> first PRBS word after the re-entry equals the first word seen after reset. Mode 3 outputs data 0 with header 6'b000010.
- Assert reset asynchronously mid-PRBS -> outputs go to 0 with no clock edge. After release, outputs follow tx_data and pattern_active = 0.
